// File: rtl/fc_pool_relu.sv
// fc_pool_relu: single-cycle ReLU / 2x2 max-pool / 4x2 fully-connected unit with registered output.
// Define FCPR_FC_SAT_EN to saturate FC results to 16 bits instead of wrapping.
module fc_pool_relu #(
  parameter int BITWIDTH       = 32,
  parameter int MP_BITWIDTH    = 8,
  parameter int FC_INPUT_SIZE  = 4,
  parameter int FC_OUTPUT_SIZE = 2
) (
  input  logic                                              clk_i,
  input  logic                                              rst_n_i,
  input  logic                                              valid_i,
  input  logic [3:0]                                        op_i,
  input  logic [31:0]                                       data1_i,
  input  logic [31:0]                                       data2_i,
  input  logic [MP_BITWIDTH*FC_INPUT_SIZE*FC_OUTPUT_SIZE-1:0] weight_i,
  output logic                                              valid_o,
  output logic [31:0]                                       data_o
);
  localparam logic [3:0] OP_RELU = 4'b0111;
  localparam logic [3:0] OP_MAX  = 4'b1000;
  localparam logic [3:0] OP_FC   = 4'b1001;
  localparam int ACC_W = 2*MP_BITWIDTH + $clog2(FC_INPUT_SIZE+1) + 1;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] relu, mp, fc, res;
  logic signed [MP_BITWIDTH-1:0]   mx;
  logic signed [2*MP_BITWIDTH-1:0] p;
  logic signed [ACC_W-1:0]         acc;
  logic                            unused;
  assign unused = ^data2_i[15:0];
  always_comb begin
    relu = data1_i[BITWIDTH-1] ? 32'h0 : data1_i;
    mx = data1_i[MP_BITWIDTH-1:0];
    for (int k = 1; k < 4; k++)
      mx = ($signed(data1_i[MP_BITWIDTH*k +: MP_BITWIDTH]) > mx) ? data1_i[MP_BITWIDTH*k +: MP_BITWIDTH] : mx;
    mp = {{(32-MP_BITWIDTH){1'b0}}, mx};
    fc = '0;
    acc = '0;
    p = '0;
    for (int j = 0; j < FC_OUTPUT_SIZE; j++) begin
      acc = ACC_W'($signed(data2_i[16+MP_BITWIDTH*j +: MP_BITWIDTH]));
      for (int i = 0; i < FC_INPUT_SIZE; i++) begin
        p = $signed(data1_i[MP_BITWIDTH*i +: MP_BITWIDTH]) *
            $signed(weight_i[MP_BITWIDTH*(FC_INPUT_SIZE*j+i) +: MP_BITWIDTH]);
        acc = acc + ACC_W'(p);
      end
`ifdef FCPR_FC_SAT_EN
      fc[16*j +: 16] = (acc > 32767) ? 16'h7FFF : (acc < -32768) ? 16'h8000 : acc[15:0];
`else
      fc[16*j +: 16] = acc[15:0];
`endif
    end
    res = (op_i == OP_RELU) ? relu :
          (op_i == OP_MAX)  ? mp   :
          (op_i == OP_FC)   ? fc   : data1_i;
    valid_d = valid_i;
    data_d  = valid_i ? res : data_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: tb/tb_fc_pool_relu.sv
// tb_fc_pool_relu: table-driven directed checks plus reset and back-to-back sequences.
module tb_fc_pool_relu;
  localparam logic [3:0] OP_RELU = 4'b0111;
  localparam logic [3:0] OP_MAX  = 4'b1000;
  localparam logic [3:0] OP_FC   = 4'b1001;
`ifdef FCPR_FC_SAT_EN
  localparam logic [31:0] EXP_OVF = 32'h7FFF7FFF;
  localparam logic [31:0] EXP_NEG = 32'h80008000;
`else
  localparam logic [31:0] EXP_OVF = 32'hFC83FC83;
  localparam logic [31:0] EXP_NEG = 32'h01800180;
`endif
  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [63:0] w;
    logic [31:0] exp;
  } vec_t;
  logic        clk = 0;
  logic        rst_n;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [31:0] data1_i, data2_i;
  logic [63:0] weight_i;
  logic        valid_o;
  logic [31:0] data_o;
  int checks = 0;
  int errors = 0;
  vec_t v[14];
  fc_pool_relu dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i), .weight_i(weight_i),
    .valid_o(valid_o), .data_o(data_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2, input logic [63:0] w);
    valid_i = 1'b1; op_i = op; data1_i = d1; data2_i = d2; weight_i = w;
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  initial begin
    v[0]  = '{OP_RELU, 32'hFFFFFFF6, 32'h0, 64'h0, 32'h00000000};
    v[1]  = '{OP_RELU, 32'h00000123, 32'h0, 64'h0, 32'h00000123};
    v[2]  = '{OP_RELU, 32'h00000000, 32'h0, 64'h0, 32'h00000000};
    v[3]  = '{OP_RELU, 32'h80000000, 32'h0, 64'h0, 32'h00000000};
    v[4]  = '{OP_RELU, 32'h7FFFFFFF, 32'h0, 64'h0, 32'h7FFFFFFF};
    v[5]  = '{OP_MAX,  32'h807F05FE, 32'hFFFFFFFF, 64'h0, 32'h0000007F};
    v[6]  = '{OP_MAX,  32'h80808080, 32'h0, 64'h0, 32'h00000080};
    v[7]  = '{OP_MAX,  32'hFEFDFCFF, 32'h0, 64'h0, 32'h000000FF};
    v[8]  = '{OP_FC,   32'h04030201, 32'hFF050000, 64'h0202020201010101, 32'h0013000F};
    v[9]  = '{OP_FC,   32'h7F7F7F7F, 32'h7F7F0000, 64'h7F7F7F7F7F7F7F7F, EXP_OVF};
    v[10] = '{OP_FC,   32'h80808080, 32'h80800000, 64'h7F7F7F7F7F7F7F7F, EXP_NEG};
    v[11] = '{OP_FC,   32'h04030201, 32'h7F800000, 64'h0, 32'h007FFF80};
    v[12] = '{4'b0000, 32'hDEADBEEF, 32'h0, 64'h0, 32'hDEADBEEF};
    v[13] = '{4'b1111, 32'h12345678, 32'h0, 64'h0, 32'h12345678};
    rst_n = 1'b0;
    drive(OP_RELU, 32'h00000055, 32'h0, 64'h0);
    step; step;
    chk("reset_valid", {31'b0, valid_o}, 32'h0);
    chk("reset_data", data_o, 32'h0);
    rst_n = 1'b1;
    valid_i = 1'b0;
    step;
    chk("idle_valid", {31'b0, valid_o}, 32'h0);
    for (int n = 0; n < 14; n++) begin
      drive(v[n].op, v[n].d1, v[n].d2, v[n].w);
      step;
      chk($sformatf("vec%0d_valid", n), {31'b0, valid_o}, 32'h1);
      chk($sformatf("vec%0d_data", n), data_o, v[n].exp);
      valid_i = 1'b0;
      data1_i = 32'hA5A5A5A5;
      step;
      chk($sformatf("vec%0d_hold_valid", n), {31'b0, valid_o}, 32'h0);
      chk($sformatf("vec%0d_hold_data", n), data_o, v[n].exp);
    end
    drive(OP_FC, 32'h04030201, 32'hFF050000, 64'h0202020201010101);
    rst_n = 1'b0;
    step;
    chk("midrst_valid", {31'b0, valid_o}, 32'h0);
    chk("midrst_data", data_o, 32'h0);
    rst_n = 1'b1;
    step;
    chk("postrst_valid", {31'b0, valid_o}, 32'h1);
    chk("postrst_data", data_o, 32'h0013000F);
    drive(OP_RELU, 32'h00000123, 32'h0, 64'h0);
    step;
    chk("b2b_relu_valid", {31'b0, valid_o}, 32'h1);
    chk("b2b_relu_data", data_o, 32'h00000123);
    drive(OP_MAX, 32'h807F05FE, 32'h0, 64'h0);
    step;
    chk("b2b_max_valid", {31'b0, valid_o}, 32'h1);
    chk("b2b_max_data", data_o, 32'h0000007F);
    drive(OP_FC, 32'h04030201, 32'hFF050000, 64'h0202020201010101);
    step;
    chk("b2b_fc_valid", {31'b0, valid_o}, 32'h1);
    chk("b2b_fc_data", data_o, 32'h0013000F);
    valid_i = 1'b0;
    step;
    chk("b2b_end_valid", {31'b0, valid_o}, 32'h0);
    chk("b2b_end_data", data_o, 32'h0013000F);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
